// File: rtl/demorgan_sweep_pkg.sv
// -----------------------------------------------------------------------------
// demorgan_sweep_pkg
// Shared types for the DeMorgan sweep controller:
//   sweep_state_t : sequencer states (IDLE, DRIVE, SETTLE, CHECK, DONE)
//   check_mask_t  : per-vector result of the four unit checks, c0 in bit 0
//   vec_space()   : size of the exhaustive {A,B} vector space for N lanes
// -----------------------------------------------------------------------------
package demorgan_sweep_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4
    } sweep_state_t;

    // bit0: nandab vs golden, bit1: norna_nb vs nandab,
    // bit2: norab vs golden,  bit3: nanda_nb vs norab
    typedef logic [3:0] check_mask_t;

    // Number of distinct {A,B} vectors for n lanes per operand.
    function automatic int unsigned vec_space(input int unsigned n);
        return 32'd1 << (32'd2 * n);
    endfunction

endpackage

// File: rtl/demorgan_sweep_ctrl_checker.sv
// -----------------------------------------------------------------------------
// dm_vec_checker
// Purely combinational comparison of the four DeMorgan unit outputs against
// golden values computed from the driven operands, and against each other.
// Ports:
//   a, b      in  N  operands currently driven into the unit
//   nandab    in  N  unit output ~(A&B)
//   norna_nb  in  N  unit output ~A|~B
//   norab     in  N  unit output ~(A|B)
//   nanda_nb  in  N  unit output ~A&~B
//   mask      out 4  per-check failure flags, c0 in bit 0
// -----------------------------------------------------------------------------
module dm_vec_checker
    import demorgan_sweep_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] nandab,
    input  logic [N-1:0] norna_nb,
    input  logic [N-1:0] norab,
    input  logic [N-1:0] nanda_nb,
    output check_mask_t  mask
);

    logic [N-1:0] gold_nand_s;
    logic [N-1:0] gold_nor_s;

    // Golden references and the four lane-reduced mismatch flags.
    always_comb begin
        gold_nand_s = ~(a & b);
        gold_nor_s  = ~(a | b);
        mask        = 4'b0000;
        mask[0]     = |(nandab   ^ gold_nand_s);
        // The DeMorgan equivalents are checked against their partner output,
        // so a fault in either one of a pair is attributed to this check.
        mask[1]     = |(norna_nb ^ nandab);
        mask[2]     = |(norab    ^ gold_nor_s);
        mask[3]     = |(nanda_nb ^ norab);
    end

endmodule

// File: rtl/demorgan_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// demorgan_sweep_ctrl
// Exhaustive sequencer for an external N-lane DeMorgan gate unit. Drives every
// {A,B} vector, waits SETTLE idle cycles, checks the four unit outputs and
// accumulates a saturating failing-vector count.
//
// Optional feature macro: DM_SWEEP_FIRST_FAIL_EN
//   When defined, adds first-failure capture ports (fail_valid/fail_vec/
//   fail_mask). Without it the block is complete and otherwise identical.
//
// Ports:
//   clk          in   1      rising-edge clock
//   rst_n        in   1      synchronous active-low reset
//   start        in   1      begin a sweep (sampled only in IDLE)
//   abort        in   1      cancel the sweep from any state
//   dm_a, dm_b   out  N      operands to the unit (registered)
//   dm_nandab    in   N      unit ~(A&B)
//   dm_norna_nb  in   N      unit ~A|~B
//   dm_norab     in   N      unit ~(A|B)
//   dm_nanda_nb  in   N      unit ~A&~B
//   busy         out  1      sweep in progress (DRIVE/SETTLE/CHECK)
//   done         out  1      one-cycle pulse on normal completion
//   pass         out  1      err_count was zero at completion
//   err_count    out  CNT_W  failing vectors, saturating
//   vec_idx      out  2N     current vector {A,B}, A in the upper half
//   fail_valid   out  1      (macro) a failure has been captured
//   fail_vec     out  2N     (macro) vector of the first failure
//   fail_mask    out  4      (macro) check mask of the first failure
// -----------------------------------------------------------------------------
module demorgan_sweep_ctrl
    import demorgan_sweep_pkg::*;
#(
    parameter int N      = 2,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [N-1:0]     dm_a,
    output logic [N-1:0]     dm_b,
    input  logic [N-1:0]     dm_nandab,
    input  logic [N-1:0]     dm_norna_nb,
    input  logic [N-1:0]     dm_norab,
    input  logic [N-1:0]     dm_nanda_nb,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [2*N-1:0]   vec_idx
`ifdef DM_SWEEP_FIRST_FAIL_EN
    ,
    output logic             fail_valid,
    output logic [2*N-1:0]   fail_vec,
    output logic [3:0]       fail_mask
`endif
);

    localparam int unsigned    V           = vec_space(N);
    localparam logic [2*N-1:0] LAST_VEC    = {(2*N){1'b1}};
    localparam logic [2*N-1:0] VEC_ONE     = {{(2*N-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ERR_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ERR_ZERO  = {CNT_W{1'b0}};
    localparam bit             HAS_SETTLE  = (SETTLE != 0);
    // Counter holds the number of SETTLE cycles still to go after the current one.
    localparam logic [3:0]     SETTLE_LOAD = 4'(SETTLE - 1);

    // Saturating increment so the count sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + ERR_ONE;
        end
        return r;
    endfunction

    sweep_state_t     state_r;
    sweep_state_t     state_s;
    logic [3:0]       settle_cnt_r;
    logic [N-1:0]     dm_a_r;
    logic [N-1:0]     dm_b_r;
    logic [2*N-1:0]   vec_idx_r;
    logic [CNT_W-1:0] err_count_r;
    logic [CNT_W-1:0] err_next_s;
    logic             busy_r;
    logic             done_r;
    logic             pass_r;
    logic             accept_s;
    logic             check_s;
    logic             fail_s;
    logic             last_vec_s;
    logic             cancel_s;
    check_mask_t      mask_s;

    dm_vec_checker #(
        .N        (N)
    ) u_checker (
        .a        (dm_a_r),
        .b        (dm_b_r),
        .nandab   (dm_nandab),
        .norna_nb (dm_norna_nb),
        .norab    (dm_norab),
        .nanda_nb (dm_nanda_nb),
        .mask     (mask_s)
    );

    // Qualifiers: start accepted, CHECK committed, abort of an active sweep.
    always_comb begin
        accept_s   = 1'b0;
        check_s    = 1'b0;
        cancel_s   = 1'b0;
        fail_s     = |mask_s;
        last_vec_s = (vec_idx_r == LAST_VEC);
        // abort beats start in IDLE so a simultaneous request is dropped
        if ((state_r == S_IDLE) && start && !abort) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        // a CHECK that coincides with abort is discarded entirely
        if ((state_r == S_CHECK) && !abort) begin
            check_s = 1'b1;
        end else begin
            check_s = 1'b0;
        end
        if ((state_r != S_IDLE) && abort) begin
            cancel_s = 1'b1;
        end else begin
            cancel_s = 1'b0;
        end
        if (check_s && fail_s) begin
            err_next_s = sat_inc(err_count_r);
        end else begin
            err_next_s = err_count_r;
        end
    end

    // Next-state decode for the sweep sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_s = S_DRIVE;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_DRIVE: begin
                if (abort) begin
                    state_s = S_IDLE;
                end else if (HAS_SETTLE) begin
                    state_s = S_SETTLE;
                end else begin
                    state_s = S_CHECK;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_s = S_IDLE;
                end else if (settle_cnt_r == 4'd0) begin
                    state_s = S_CHECK;
                end else begin
                    state_s = S_SETTLE;
                end
            end
            S_CHECK: begin
                if (abort) begin
                    state_s = S_IDLE;
                end else if (last_vec_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_DRIVE;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State register and settle-cycle down-counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            settle_cnt_r <= 4'd0;
        end else begin
            state_r <= state_s;
            if (state_r == S_DRIVE) begin
                settle_cnt_r <= SETTLE_LOAD;
            end else if ((state_r == S_SETTLE) && (settle_cnt_r != 4'd0)) begin
                settle_cnt_r <= settle_cnt_r - 4'd1;
            end else begin
                settle_cnt_r <= settle_cnt_r;
            end
        end
    end

    // Vector index, operand drive and error counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_idx_r   <= {(2*N){1'b0}};
            err_count_r <= ERR_ZERO;
            dm_a_r      <= {N{1'b0}};
            dm_b_r      <= {N{1'b0}};
        end else begin
            if (accept_s) begin
                vec_idx_r   <= {(2*N){1'b0}};
                err_count_r <= ERR_ZERO;
            end else if (check_s) begin
                err_count_r <= err_next_s;
                // the final index is kept so it reads V-1 at completion
                if (!last_vec_s) begin
                    vec_idx_r <= vec_idx_r + VEC_ONE;
                end else begin
                    vec_idx_r <= vec_idx_r;
                end
            end else begin
                vec_idx_r   <= vec_idx_r;
                err_count_r <= err_count_r;
            end
            // operands persist after done/abort until the next DRIVE
            if (state_r == S_DRIVE) begin
                dm_a_r <= vec_idx_r[2*N-1:N];
                dm_b_r <= vec_idx_r[N-1:0];
            end else begin
                dm_a_r <= dm_a_r;
                dm_b_r <= dm_b_r;
            end
        end
    end

    // Registered status flags, derived from the upcoming state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            pass_r <= 1'b0;
        end else begin
            busy_r <= (state_s == S_DRIVE) || (state_s == S_SETTLE) ||
                      (state_s == S_CHECK);
            done_r <= (state_s == S_DONE);
            if (accept_s || cancel_s) begin
                pass_r <= 1'b0;
            end else if (state_s == S_DONE) begin
                pass_r <= (err_next_s == ERR_ZERO);
            end else begin
                pass_r <= pass_r;
            end
        end
    end

`ifdef DM_SWEEP_FIRST_FAIL_EN
    logic             fail_valid_r;
    logic [2*N-1:0]   fail_vec_r;
    check_mask_t      fail_mask_r;

    // First-failure capture; later failures never overwrite it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fail_valid_r <= 1'b0;
            fail_vec_r   <= {(2*N){1'b0}};
            fail_mask_r  <= 4'b0000;
        end else if (accept_s) begin
            fail_valid_r <= 1'b0;
            fail_vec_r   <= {(2*N){1'b0}};
            fail_mask_r  <= 4'b0000;
        end else if (check_s && fail_s && !fail_valid_r) begin
            fail_valid_r <= 1'b1;
            fail_vec_r   <= vec_idx_r;
            fail_mask_r  <= mask_s;
        end else begin
            fail_valid_r <= fail_valid_r;
            fail_vec_r   <= fail_vec_r;
            fail_mask_r  <= fail_mask_r;
        end
    end

    assign fail_valid = fail_valid_r;
    assign fail_vec   = fail_vec_r;
    assign fail_mask  = fail_mask_r;
`endif

    assign dm_a      = dm_a_r;
    assign dm_b      = dm_b_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign err_count = err_count_r;
    assign vec_idx   = vec_idx_r;

endmodule

// File: tb/tb_demorgan_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_demorgan_sweep_ctrl
// Scoreboard bench: each accepted start pushes the expected completion record
// (pass, err_count, vec_idx, done cycle); a monitor pops it on every done pulse.
// A second instance (SETTLE=0, CNT_W=2) covers counter saturation.
// -----------------------------------------------------------------------------
module tb_demorgan_sweep_ctrl;

    localparam int N      = 2;
    localparam int SETTLE = 1;
    localparam int V      = 16;
    localparam int SWEEP  = V * (2 + SETTLE) + 1;   // start-cycle to done-cycle
    localparam int BUSY_N = V * (2 + SETTLE);
    localparam int SWEEP1 = V * 2 + 1;              // second instance, SETTLE=0

    typedef struct packed {
        logic        pass;
        logic [7:0]  err;
        logic [3:0]  vec;
        logic [31:0] cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [1:0] dm_a, dm_b;
    logic [1:0] dm_nandab, dm_norna_nb, dm_norab, dm_nanda_nb;
    logic       busy, done, pass;
    logic [7:0] err_count;
    logic [3:0] vec_idx;
    logic [1:0] unit_mode;

    logic       start1;
    logic       abort1;
    logic [1:0] dm_a1, dm_b1;
    logic [1:0] nandab1, norna_nb1, norab1, nanda_nb1;
    logic       busy1, done1, pass1;
    logic [1:0] err_count1;
    logic [3:0] vec_idx1;

`ifdef DM_SWEEP_FIRST_FAIL_EN
    logic       fail_valid, fail_valid1;
    logic [3:0] fail_vec, fail_vec1;
    logic [3:0] fail_mask, fail_mask1;
`endif

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   busy_run = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    // Cycle counter used to time done pulses.
    always @(posedge clk) cyc <= cyc + 1;

    // Unit model for the main instance: 0 correct, 1 norab lane0 stuck 0, 2 all inverted.
    always_comb begin
        dm_nandab   = ~(dm_a & dm_b);
        dm_norna_nb = ~(dm_a & dm_b);
        dm_norab    = ~(dm_a | dm_b);
        dm_nanda_nb = ~(dm_a | dm_b);
        case (unit_mode)
            2'd1: dm_norab = ~(dm_a | dm_b) & 2'b10;
            2'd2: begin
                dm_nandab   = dm_a & dm_b;
                dm_norna_nb = dm_a & dm_b;
                dm_norab    = dm_a | dm_b;
                dm_nanda_nb = dm_a | dm_b;
            end
            default: ;
        endcase
    end

    // Always-inverted unit model for the saturation instance.
    always_comb begin
        nandab1   = dm_a1 & dm_b1;
        norna_nb1 = dm_a1 & dm_b1;
        norab1    = dm_a1 | dm_b1;
        nanda_nb1 = dm_a1 | dm_b1;
    end

    demorgan_sweep_ctrl #(.N(N), .SETTLE(SETTLE), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .dm_a        (dm_a),
        .dm_b        (dm_b),
        .dm_nandab   (dm_nandab),
        .dm_norna_nb (dm_norna_nb),
        .dm_norab    (dm_norab),
        .dm_nanda_nb (dm_nanda_nb),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .err_count   (err_count),
        .vec_idx     (vec_idx)
`ifdef DM_SWEEP_FIRST_FAIL_EN
        ,
        .fail_valid  (fail_valid),
        .fail_vec    (fail_vec),
        .fail_mask   (fail_mask)
`endif
    );

    demorgan_sweep_ctrl #(.N(N), .SETTLE(0), .CNT_W(2)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start1),
        .abort       (abort1),
        .dm_a        (dm_a1),
        .dm_b        (dm_b1),
        .dm_nandab   (nandab1),
        .dm_norna_nb (norna_nb1),
        .dm_norab    (norab1),
        .dm_nanda_nb (nanda_nb1),
        .busy        (busy1),
        .done        (done1),
        .pass        (pass1),
        .err_count   (err_count1),
        .vec_idx     (vec_idx1)
`ifdef DM_SWEEP_FIRST_FAIL_EN
        ,
        .fail_valid  (fail_valid1),
        .fail_vec    (fail_vec1),
        .fail_mask   (fail_mask1)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected record.
    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("done_pass",  32'(pass),      32'(mon_e.pass));
                check("done_err",   32'(err_count), 32'(mon_e.err));
                check("done_vec",   32'(vec_idx),   32'(mon_e.vec));
                check("done_cycle", 32'(cyc),       mon_e.cyc);
                check("busy_len",   32'(busy_run),  32'(BUSY_N));
            end
            busy_run = 0;
        end else if (busy) begin
            busy_run++;
        end else begin
            busy_run = 0;
        end
    end

    task automatic issue_start(input logic p, input logic [7:0] e, input logic [3:0] v);
        sb_q.push_back('{pass: p, err: e, vec: v, cyc: 32'(cyc + SWEEP)});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while ((sb_q.size() != 0 || busy || done) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("drain_timeout", 32'(k < budget), 32'd1);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy),      32'd0);
        check({tag, "_done"}, 32'(done),      32'd0);
        check({tag, "_pass"}, 32'(pass),      32'd0);
        check({tag, "_err"},  32'(err_count), 32'd0);
        check({tag, "_vec"},  32'(vec_idx),   32'd0);
        check({tag, "_dma"},  32'(dm_a),      32'd0);
        check({tag, "_dmb"},  32'(dm_b),      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int k;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; unit_mode = 2'd0;
        start1 = 1'b0; abort1 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_all_zero("reset");

        // 1: correct unit, full sweep passes; operands hold last vector; pass holds
        unit_mode = 2'd0;
        issue_start(1'b1, 8'd0, 4'hF);
        wait_drain(200);
        check("t1_dma_hold", 32'(dm_a), 32'd3);
        check("t1_dmb_hold", 32'(dm_b), 32'd3);
        repeat (3) @(negedge clk);
        check("t1_pass_held", 32'(pass), 32'd1);
`ifdef DM_SWEEP_FIRST_FAIL_EN
        check("t1_fail_valid", 32'(fail_valid), 32'd0);
`endif

        // 2: norab lane0 stuck 0 -> fails only where a0=b0=0 (vectors 0,2,8,10)
        unit_mode = 2'd1;
        issue_start(1'b0, 8'd4, 4'hF);
        check("t2_pass_cleared", 32'(pass), 32'd0);
        wait_drain(200);
`ifdef DM_SWEEP_FIRST_FAIL_EN
        check("t2_fail_valid", 32'(fail_valid), 32'd1);
        check("t2_fail_vec",   32'(fail_vec),   32'h0);
        check("t2_fail_mask",  32'(fail_mask),  32'b1100);
`endif

        // 3: all-inverted unit, abort during CHECK of vector 4 (cycle c0+15)
        unit_mode = 2'd2;
        c0 = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        check("t3_vec_at_abort", 32'(vec_idx), 32'd4);
        check("t3_busy_at_abort", 32'(busy), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t3_busy",  32'(busy),      32'd0);
        check("t3_done",  32'(done),      32'd0);
        check("t3_pass",  32'(pass),      32'd0);
        check("t3_vec",   32'(vec_idx),   32'd4);
        check("t3_err",   32'(err_count), 32'd4);
        check("t3_dma",   32'(dm_a),      32'd1);
        check("t3_dmb",   32'(dm_b),      32'd0);
`ifdef DM_SWEEP_FIRST_FAIL_EN
        check("t3_fail_vec",  32'(fail_vec),  32'h0);
        check("t3_fail_mask", 32'(fail_mask), 32'b0101);
`endif
        // start together with abort in IDLE is dropped
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (2) @(negedge clk);
        check("t3_sa_busy", 32'(busy),      32'd0);
        check("t3_sa_vec",  32'(vec_idx),   32'd4);
        check("t3_sa_err",  32'(err_count), 32'd4);

        // 4: start held high -> back-to-back sweeps, one IDLE cycle between
        unit_mode = 2'd0;
        c0 = cyc;
        sb_q.push_back('{pass: 1'b1, err: 8'd0, vec: 4'hF, cyc: 32'(c0 + SWEEP)});
        sb_q.push_back('{pass: 1'b1, err: 8'd0, vec: 4'hF, cyc: 32'(c0 + 2 * SWEEP + 1)});
        start = 1'b1;
        k = 0;
        while (cyc < c0 + 2 * SWEEP + 1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        wait_drain(50);
        repeat (4) @(negedge clk);
        check("t4_no_third", 32'(busy), 32'd0);

        // 5: reset during SETTLE of vector 2, then a clean full sweep
        unit_mode = 2'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("t5_err_before", 32'(err_count), 32'd2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_all_zero("t5_reset");
`ifdef DM_SWEEP_FIRST_FAIL_EN
        check("t5_fail_valid", 32'(fail_valid), 32'd0);
`endif
        unit_mode = 2'd0;
        issue_start(1'b1, 8'd0, 4'hF);
        wait_drain(200);

        // 6: CNT_W=2, SETTLE=0, all-inverted -> saturates at 3
        c0 = cyc;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        k = 0;
        while (!done1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("t6_done_seen",  32'(done1),      32'd1);
        check("t6_done_cycle", 32'(cyc),        32'(c0 + SWEEP1));
        check("t6_err_sat",    32'(err_count1), 32'd3);
        check("t6_pass",       32'(pass1),      32'd0);
        check("t6_vec",        32'(vec_idx1),   32'hF);
        @(negedge clk);
        check("t6_done_pulse", 32'(done1), 32'd0);

        repeat (2) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
